// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control/branch inputs from decode/execute and I-mem, fetch and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is the surrounding pipeline.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        branch;
  logic        cond_branch;
  logic        zero;
  logic [63:0] bus_imm;
  logic [63:0] branch_pc;
  logic [31:0] instr_in;
  logic [63:0] pc;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        align_err;
  logic [31:0] fetch_count;

  modport master (
    output stall, flush, branch, cond_branch, zero, bus_imm, branch_pc, instr_in,
    input  pc, ifid_pc, ifid_instr, ifid_valid, align_err, fetch_count
  );

  modport slave (
    input  stall, flush, branch, cond_branch, zero, bus_imm, branch_pc, instr_in,
    output pc, ifid_pc, ifid_instr, ifid_valid, align_err, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register plus IF/ID register; one-cycle latency, redirect costs one bubble.
// Stall holds PC and IF/ID; a taken branch overrides stall, and flush or taken squashes IF/ID.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.slave  bus
);

  logic        taken;
  logic [63:0] target;
  logic [63:0] pc_q, pc_nxt;
  logic [63:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic        align_err_q;
  logic [31:0] fetch_count_q;

  // Zero only matters when cond_branch is set; the AND masks an unknown flag.
  always_comb begin
    taken  = bus.branch | (bus.cond_branch & bus.zero);
    target = bus.branch_pc + bus.bus_imm;
    pc_nxt = pc_q + 64'd4;
    if (taken) begin
      pc_nxt = {target[63:2], 2'b00};
    end else if (bus.stall) begin
      pc_nxt = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= 64'h0;
      ifid_instr_q  <= 32'h0;
      ifid_valid_q  <= 1'b0;
      align_err_q   <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q <= pc_nxt;
      // The instruction fetched alongside a redirect is wrong-path, so it becomes the bubble.
      if (taken || bus.flush) begin
        ifid_pc_q    <= 64'h0;
        ifid_instr_q <= 32'h0;
        ifid_valid_q <= 1'b0;
      end else if (!bus.stall) begin
        ifid_pc_q     <= pc_q;
        ifid_instr_q  <= bus.instr_in;
        ifid_valid_q  <= 1'b1;
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (taken && (target[1:0] != 2'b00)) begin
        align_err_q <= 1'b1;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_instr  = ifid_instr_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.align_err   = align_err_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations plus random traffic vs a reference model.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   fails = 0;

  if_stage_if bus ();
  if_stage_if bus2 ();

  if_stage u_dut (.clk(clk), .rst(rst), .bus(bus));
  if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  // Instruction memory stand-in: a constant word or an address hash.
  logic        const_mode = 1'b1;
  logic [31:0] const_instr = 32'h8B02_0020;

  function automatic logic [31:0] imem(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always_comb bus.instr_in = const_mode ? const_instr : imem(bus.pc);

  initial begin
    bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.branch = 1'b0; bus2.cond_branch = 1'b0;
    bus2.zero = 1'b0; bus2.bus_imm = 64'h0; bus2.branch_pc = 64'h0; bus2.instr_in = 32'h1111_2222;
  end

  // Reference model state, advanced from the rules at every edge of the main DUT.
  logic [63:0] m_pc, m_ifid_pc;
  logic [31:0] m_ifid_instr, m_cnt;
  logic        m_valid, m_align;

  task automatic model_reset();
    m_pc = 64'h0; m_ifid_pc = 64'h0; m_ifid_instr = 32'h0;
    m_valid = 1'b0; m_align = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step();
    logic        t;
    logic [63:0] tg;
    logic [31:0] ins;
    t   = bus.branch || (bus.cond_branch && (bus.zero === 1'b1));
    tg  = bus.branch_pc + bus.bus_imm;
    ins = const_mode ? const_instr : imem(m_pc);
    if (t || bus.flush) begin
      m_ifid_pc = 64'h0; m_ifid_instr = 32'h0; m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_ifid_pc = m_pc; m_ifid_instr = ins; m_valid = 1'b1; m_cnt = m_cnt + 1;
    end
    if (t) m_pc = tg & ~64'h3;
    else if (!bus.stall) m_pc = m_pc + 64'd4;
    if (t && tg[1:0] != 2'b00) m_align = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch = 1'b0; bus.cond_branch = 1'b0;
    bus.zero = 1'b0; bus.bus_imm = 64'h0; bus.branch_pc = 64'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.stall = 1'b1; bus.branch = 1'b1; bus.branch_pc = 64'h40; bus.bus_imm = 64'h8;
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 64'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", bus.pc); end
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 64'h0 || bus.ifid_instr !== 32'h0)
      begin fails++; $display("FAIL rst_ifid: got v=%b pc=%h i=%h want zeros", bus.ifid_valid, bus.ifid_pc, bus.ifid_instr); end
    checks++; if (bus.align_err !== 1'b0 || bus.fetch_count !== 32'h0)
      begin fails++; $display("FAIL rst_flags: got ae=%b cnt=%0d want 0/0", bus.align_err, bus.fetch_count); end
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #1;
    checks++; if (bus.pc !== 64'h0 || bus.ifid_valid !== 1'b0)
      begin fails++; $display("FAIL rst_release_hold: got pc=%h v=%b want 0/0", bus.pc, bus.ifid_valid); end
    tick();
    checks++; if (bus.ifid_pc !== 64'h0 || bus.ifid_valid !== 1'b1 || bus.pc !== 64'h4)
      begin fails++; $display("FAIL rst_first_fetch: got ifid_pc=%h v=%b pc=%h want 0/1/4", bus.ifid_pc, bus.ifid_valid, bus.pc); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.pc !== 64'(4 * i)) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, 64'(4 * i)); end
      checks++; if (bus.ifid_pc !== 64'(4 * (i - 1)) || bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 32'h8B02_0020)
        begin fails++; $display("FAIL seq_ifid%0d: got pc=%h v=%b i=%h", i, bus.ifid_pc, bus.ifid_valid, bus.ifid_instr); end
    end
    checks++; if (bus.fetch_count !== 32'd3) begin fails++; $display("FAIL seq_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_branch();
    do_reset();
    tick(); tick();
    bus.branch = 1'b1; bus.branch_pc = 64'h4; bus.bus_imm = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 64'h0 || bus.ifid_valid !== 1'b0)
      begin fails++; $display("FAIL br_redirect: got pc=%h v=%b want 0/0", bus.pc, bus.ifid_valid); end
    checks++; if (bus.fetch_count !== 32'd2) begin fails++; $display("FAIL br_count: got %0d want 2", bus.fetch_count); end
    tick();
    checks++; if (bus.ifid_pc !== 64'h0 || bus.ifid_valid !== 1'b1 || bus.pc !== 64'h4)
      begin fails++; $display("FAIL br_target_fetch: got ifid_pc=%h v=%b pc=%h want 0/1/4", bus.ifid_pc, bus.ifid_valid, bus.pc); end
  endtask

  task automatic test_cond_branch();
    do_reset();
    bus.cond_branch = 1'b1; bus.zero = 1'b0; bus.bus_imm = 64'h10; bus.branch_pc = 64'h0;
    tick();
    checks++; if (bus.pc !== 64'h4 || bus.ifid_valid !== 1'b1)
      begin fails++; $display("FAIL cb_not_taken: got pc=%h v=%b want 4/1", bus.pc, bus.ifid_valid); end
    bus.zero = 1'b1; bus.branch_pc = 64'h8;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 64'h18 || bus.ifid_valid !== 1'b0)
      begin fails++; $display("FAIL cb_taken: got pc=%h v=%b want 18/0", bus.pc, bus.ifid_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    bus.stall = 1'b1;
    tick(); tick();
    checks++; if (bus.pc !== 64'hC || bus.ifid_pc !== 64'h8 || bus.ifid_valid !== 1'b1)
      begin fails++; $display("FAIL stall_hold: got pc=%h ifid_pc=%h v=%b want c/8/1", bus.pc, bus.ifid_pc, bus.ifid_valid); end
    checks++; if (bus.fetch_count !== 32'd3) begin fails++; $display("FAIL stall_count: got %0d want 3", bus.fetch_count); end
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.pc !== 64'hC || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 64'h0)
      begin fails++; $display("FAIL stall_flush: got pc=%h v=%b ifid_pc=%h want c/0/0", bus.pc, bus.ifid_valid, bus.ifid_pc); end
    bus.flush = 1'b0; bus.branch = 1'b1; bus.branch_pc = 64'h0; bus.bus_imm = 64'h20;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 64'h20 || bus.ifid_valid !== 1'b0 || bus.fetch_count !== 32'd3)
      begin fails++; $display("FAIL stall_branch: got pc=%h v=%b cnt=%0d want 20/0/3", bus.pc, bus.ifid_valid, bus.fetch_count); end
  endtask

  task automatic test_align();
    do_reset();
    bus.branch = 1'b1; bus.branch_pc = 64'h0; bus.bus_imm = 64'h6;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 64'h4 || bus.align_err !== 1'b1)
      begin fails++; $display("FAIL align_set: got pc=%h ae=%b want 4/1", bus.pc, bus.align_err); end
    tick(); tick();
    checks++; if (bus.align_err !== 1'b1 || bus.fetch_count !== 32'd2)
      begin fails++; $display("FAIL align_sticky: got ae=%b cnt=%0d want 1/2", bus.align_err, bus.fetch_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.align_err !== 1'b0 || bus.pc !== 64'h0 || bus.fetch_count !== 32'h0 || bus.ifid_valid !== 1'b0)
      begin fails++; $display("FAIL align_async_rst: got ae=%b pc=%h cnt=%0d v=%b want zeros", bus.align_err, bus.pc, bus.fetch_count, bus.ifid_valid); end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    checks++; if (bus2.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_rst_pc: got %h want fffffffffffffffc", bus2.pc); end
    rst2 = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus2.pc !== 64'h0 || bus2.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
      begin fails++; $display("FAIL wrap_edge1: got pc=%h ifid_pc=%h want 0/fffffffffffffffc", bus2.pc, bus2.ifid_pc); end
    @(posedge clk); #1;
    checks++; if (bus2.pc !== 64'h4 || bus2.fetch_count !== 32'd2 || bus2.ifid_instr !== 32'h1111_2222)
      begin fails++; $display("FAIL wrap_edge2: got pc=%h cnt=%0d i=%h want 4/2/11112222", bus2.pc, bus2.fetch_count, bus2.ifid_instr); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    const_mode = 1'b0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      bus.stall       = (r[1:0] == 2'b00);
      bus.flush       = (r[5:2] == 4'h0);
      bus.branch      = (r[9:6] == 4'h0);
      bus.cond_branch = (r[12:10] == 3'b000);
      bus.zero        = bus.cond_branch ? r[13] : 1'bx;
      bus.bus_imm     = {{50{r[27]}}, r[27:16], (r[14:13] == 2'b11) ? 2'b10 : 2'b00};
      bus.branch_pc   = {32'h0, $urandom} & 64'h0000_0000_000F_FFFC;
      tick();
      checks++;
      if (bus.pc !== m_pc || bus.ifid_pc !== m_ifid_pc || bus.ifid_instr !== m_ifid_instr ||
          bus.ifid_valid !== m_valid || bus.align_err !== m_align || bus.fetch_count !== m_cnt) begin
        fails++;
        $display("FAIL rand_cycle%0d: got pc=%h ifid=%h/%h/%b ae=%b cnt=%0d want pc=%h ifid=%h/%h/%b ae=%b cnt=%0d",
                 n, bus.pc, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid, bus.align_err, bus.fetch_count,
                 m_pc, m_ifid_pc, m_ifid_instr, m_valid, m_align, m_cnt);
      end
    end
    clear_inputs();
    const_mode = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_cond_branch();
    test_stall();
    test_align();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
